// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 opcode/funct7 constants and issue-stage FSM states.
// The ALU itself decodes the same op codes.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_REM = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // funct3 map shared by R-type (funct7=0) and I-type
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32 ALU instruction decode: opcode/funct3/funct7 to ALU op code.
// Anything unsupported comes out as ALU_NOP with illegal set.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_op_o,
  output logic       is_md_o,
  output logic       use_imm_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_NOP;
    use_imm_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        case (funct7_i)
          F7_BASE: alu_op_o = base_op(funct3_i);
          F7_ALT:  if (funct3_i == 3'b000) alu_op_o = ALU_SUB;
          F7_MD: begin
            case (funct3_i)
              3'b000:  alu_op_o = ALU_MUL;
              3'b100:  alu_op_o = ALU_DIV;
              3'b110:  alu_op_o = ALU_REM;
              default: alu_op_o = ALU_NOP;
            endcase
          end
          default: alu_op_o = ALU_NOP;
        endcase
      end
      OP_I: begin
        use_imm_o = 1'b1;
        // srai shares funct3 with srli; only the funct7=0 shift forms are legal
        if (!((funct3_i == 3'b001) || (funct3_i == 3'b101)) || (funct7_i == F7_BASE))
          alu_op_o = base_op(funct3_i);
      end
      default: alu_op_o = ALU_NOP;
    endcase
  end

  assign illegal_o = (alu_op_o == ALU_NOP);
  assign is_md_o   = is_md_op(alu_op_o);

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: forwards, decodes and drives the ALU, waits its latency, holds result.
// Optional ALU_ISSUE_DIV0_TRAP_EN: div/rem by zero finishes in 1 cycle with RISC-V defined result.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam logic [3:0] MD_CNT = 4'(MD_LAT);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [XLEN-1:0]   alu_a_q, alu_b_q;
  logic [3:0]        alu_op_q;
  logic [4:0]        rd_q;
  logic              ill_q, div0_q;
  logic              out_valid_q, out_illegal_q;
  logic [XLEN-1:0]   out_result_q;
  logic [4:0]        out_rd_q;

  logic [3:0]        dec_op;
  logic              dec_md, dec_imm, dec_ill;
  logic [XLEN-1:0]   a_d, b_d, rs2_fwd, cap_val;
  logic              shamt_imm, div0_d, accept;
  logic [3:0]        cnt_d;

  alu_op_decode u_dec (
    .opcode_i  (in_opcode),
    .funct3_i  (in_funct3),
    .funct7_i  (in_funct7),
    .alu_op_o  (dec_op),
    .is_md_o   (dec_md),
    .use_imm_o (dec_imm),
    .illegal_o (dec_ill)
  );

  // Forwarding is sampled only in the accept cycle; x0 never forwards
  assign a_d       = (fwd_valid && fwd_rd == in_rs1 && in_rs1 != 5'd0) ? fwd_data : in_rs1_val;
  assign rs2_fwd   = (fwd_valid && fwd_rd == in_rs2 && in_rs2 != 5'd0) ? fwd_data : in_rs2_val;
  assign shamt_imm = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign b_d       = dec_imm ? (shamt_imm ? {{(XLEN-5){1'b0}}, in_imm[4:0]} : in_imm) : rs2_fwd;

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign div0_d = ((dec_op == ALU_DIV) || (dec_op == ALU_REM)) && (b_d == '0);
`else
  assign div0_d = 1'b0;
`endif

  assign cnt_d    = (dec_md && !div0_d) ? MD_CNT : 4'd1;
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    cap_val = alu_result;
    if (ill_q)       cap_val = '0;
    else if (div0_q) cap_val = (alu_op_q == ALU_DIV) ? '1 : alu_a_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= ALU_NOP;
      rd_q          <= '0;
      ill_q         <= 1'b0;
      div0_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) state_q <= ST_EXEC;
        ST_EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            out_result_q  <= cap_val;
            out_rd_q      <= rd_q;
            out_illegal_q <= ill_q;
            out_valid_q   <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= in_valid ? ST_EXEC : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Accept happens only in IDLE or a draining DONE, never alongside an EXEC decrement
      if (accept) begin
        alu_a_q  <= a_d;
        alu_b_q  <= b_d;
        alu_op_q <= dec_op;
        rd_q     <= in_rd;
        ill_q    <= dec_ill;
        div0_q   <= div0_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized ops against an
// instruction-level reference model; a behavioural ALU sits on the alu_* interface.
module tb_alu_issue_stage;

  localparam int MD_LAT = 4;
  localparam logic [6:0] R_OPC = 7'b0110011;
  localparam logic [6:0] I_OPC = 7'b0010011;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1, in_rs2, in_rd, fwd_rd, out_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, fwd_data;
  logic        fwd_valid;
  logic [31:0] alu_a, alu_b, alu_result, out_result;
  logic [3:0]  alu_op;
  logic        out_valid, out_ready, out_illegal;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  logic        exp_ill;

  typedef struct {
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd, frd;
    logic [31:0] v1, v2, imm, fdata;
    logic        fv;
  } ins_t;

  alu_issue_stage #(.MD_LAT(MD_LAT), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
    return $signed(a) % $signed(b);
  endfunction

  // Behavioural ALU; unknown op codes return junk so illegal results must come from the stage
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a * b;
      4'b0011: return sdiv(a, b);
      4'b0100: return srem(a, b);
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return a & b;
      4'b1000: return a << b[4:0];
      4'b1001: return a >> b[4:0];
      4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Instruction-level reference: mnemonic semantics, expected ALU op, operands and latency
  task automatic ref_eval(input ins_t t, output logic ill, output logic [31:0] res,
                          output logic [3:0] op, output logic [31:0] ea,
                          output logic [31:0] eb, output int lat);
    logic [31:0] a, b;
    a = (t.fv && t.frd == t.rs1 && t.rs1 != 5'd0) ? t.fdata : t.v1;
    b = (t.fv && t.frd == t.rs2 && t.rs2 != 5'd0) ? t.fdata : t.v2;
    ill = 1'b0; op = 4'b1111; res = 32'd0; ea = a; eb = b; lat = 1;
    if (t.opc == R_OPC) begin
      case ({t.f7, t.f3})
        {7'h00, 3'd0}: begin op = 4'b0000; res = a + b; end
        {7'h20, 3'd0}: begin op = 4'b0001; res = a - b; end
        {7'h00, 3'd1}: begin op = 4'b1000; res = a << b[4:0]; end
        {7'h00, 3'd2}: begin op = 4'b1010; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        {7'h00, 3'd4}: begin op = 4'b0110; res = a ^ b; end
        {7'h00, 3'd5}: begin op = 4'b1001; res = a >> b[4:0]; end
        {7'h00, 3'd6}: begin op = 4'b0101; res = a | b; end
        {7'h00, 3'd7}: begin op = 4'b0111; res = a & b; end
        {7'h01, 3'd0}: begin op = 4'b0010; res = a * b; lat = MD_LAT; end
        {7'h01, 3'd4}: begin op = 4'b0011; res = sdiv(a, b); lat = MD_LAT; end
        {7'h01, 3'd6}: begin op = 4'b0100; res = srem(a, b); lat = MD_LAT; end
        default: ill = 1'b1;
      endcase
    end else if (t.opc == I_OPC) begin
      eb = t.imm;
      case (t.f3)
        3'd0: begin op = 4'b0000; res = a + t.imm; end
        3'd2: begin op = 4'b1010; res = ($signed(a) < $signed(t.imm)) ? 32'd1 : 32'd0; end
        3'd4: begin op = 4'b0110; res = a ^ t.imm; end
        3'd6: begin op = 4'b0101; res = a | t.imm; end
        3'd7: begin op = 4'b0111; res = a & t.imm; end
        3'd1: if (t.f7 == 7'h00) begin
                op = 4'b1000; eb = {27'd0, t.imm[4:0]}; res = a << t.imm[4:0];
              end else ill = 1'b1;
        3'd5: if (t.f7 == 7'h00) begin
                op = 4'b1001; eb = {27'd0, t.imm[4:0]}; res = a >> t.imm[4:0];
              end else ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end else begin
      ill = 1'b1;
    end
    if (ill) begin op = 4'b1111; res = 32'd0; lat = 1; end
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    if ((op == 4'b0011 || op == 4'b0100) && eb == 32'd0) lat = 1;
`endif
  endtask

  function automatic ins_t mk(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [4:0] rd);
    ins_t t;
    t.opc = opc; t.f7 = f7; t.f3 = f3; t.rs1 = rs1; t.rs2 = rs2; t.v1 = v1; t.v2 = v2;
    t.imm = imm; t.rd = rd; t.fv = 1'b0; t.frd = 5'd0; t.fdata = 32'd0;
    return t;
  endfunction

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
  endfunction

  function automatic ins_t rnd_ins();
    ins_t t;
    int r;
    r = $urandom_range(0, 9);
    t.opc = (r < 5) ? R_OPC : (r < 9) ? I_OPC : 7'($urandom);
    case ($urandom_range(0, 3))
      0:       t.f7 = 7'h00;
      1:       t.f7 = 7'h20;
      2:       t.f7 = 7'h01;
      default: t.f7 = 7'($urandom);
    endcase
    if (t.opc == I_OPC && $urandom_range(0, 2) != 0) t.f7 = 7'h00;
    t.f3 = 3'($urandom);
    t.rs1 = 5'($urandom_range(0, 7)); t.rs2 = 5'($urandom_range(0, 7));
    t.rd = 5'($urandom);
    t.v1 = rnd_val(); t.v2 = rnd_val();
    t.imm = {{20{1'b0}}, 12'($urandom)};
    if (t.imm[11]) t.imm[31:12] = '1;
    t.fv = 1'($urandom); t.frd = 5'($urandom_range(0, 7)); t.fdata = rnd_val();
    return t;
  endfunction

  // Called #1 after a posedge; chained means the previous result is being drained this cycle
  task automatic issue(input ins_t t, input bit chained);
    logic ill;
    logic [31:0] res, ea, eb;
    logic [3:0] eop;
    int elat, lat, rdy_hi;
    ref_eval(t, ill, res, eop, ea, eb, elat);
    in_opcode = t.opc; in_funct3 = t.f3; in_funct7 = t.f7;
    in_rs1 = t.rs1; in_rs2 = t.rs2; in_rs1_val = t.v1; in_rs2_val = t.v2;
    in_imm = t.imm; in_rd = t.rd;
    fwd_valid = t.fv; fwd_rd = t.frd; fwd_data = t.fdata;
    in_valid = 1'b1; out_ready = chained;
    #3;
    chk("acc_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    fwd_valid = 1'($urandom); fwd_data = 32'($urandom);
    in_rs1_val = 32'($urandom); in_rs2_val = 32'($urandom);
    chk("exec_rdy", 32'(in_ready), 32'd0);
    chk("alu_op", 32'(alu_op), 32'(eop));
    if (!ill) begin
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
    end
    lat = -1; rdy_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
      if (in_ready) rdy_hi++;
    end
    chk("lat", 32'(lat), 32'(elat));
    chk("busy_rdy", 32'(rdy_hi), 32'd0);
    chk("result", out_result, res);
    chk("rd", 32'(out_rd), 32'(t.rd));
    chk("illegal", 32'(out_illegal), 32'(ill));
    exp_res = res; exp_rd = t.rd; exp_ill = ill;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_rdy", 32'(in_ready), 32'd0);
      chk("hold_res", out_result, exp_res);
      chk("hold_rd", 32'(out_rd), 32'(exp_rd));
      chk("hold_ill", 32'(out_illegal), 32'(exp_ill));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    #3;
    chk("done_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_vld", 32'(out_valid), 32'd0);
    chk("idle_rdy", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t t;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rs1 = '0; in_rs2 = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_rd = '0;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_op", 32'(alu_op), 32'hF);
    chk("rst_res", out_result, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_ill", 32'(out_illegal), 32'd0);

    // add x3 = 5 + 7
    issue(mk(R_OPC, 7'h00, 3'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 5'd3), 0);
    release_out();
    // sub with rs1 forwarded, then rs1=x0 ignores forwarding
    t = mk(R_OPC, 7'h20, 3'd0, 5'd4, 5'd5, 32'd55, 32'd30, 32'd0, 5'd6);
    t.fv = 1'b1; t.frd = 5'd4; t.fdata = 32'd100;
    issue(t, 0); release_out();
    t.rs1 = 5'd0; t.frd = 5'd0;
    issue(t, 0); release_out();
    // mul/div/rem latency
    issue(mk(R_OPC, 7'h01, 3'd0, 5'd1, 5'd2, 32'd6, 32'd7, 32'd0, 5'd7), 0);  release_out();
    issue(mk(R_OPC, 7'h01, 3'd4, 5'd1, 5'd2, 32'd100, 32'd7, 32'd0, 5'd8), 0); release_out();
    issue(mk(R_OPC, 7'h01, 3'd6, 5'd1, 5'd2, 32'd100, 32'd7, 32'd0, 5'd9), 0); release_out();
    // backpressure, then drain and accept in the same cycle
    issue(mk(I_OPC, 7'h00, 3'd1, 5'd1, 5'd0, 32'd3, 32'd0, 32'hFFFF_FFE4, 5'd10), 0);
    hold(3);
    issue(mk(R_OPC, 7'h00, 3'd7, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0, 32'd0, 5'd11), 1);
    release_out();
    // sra and sltu are not executable
    issue(mk(R_OPC, 7'h20, 3'd5, 5'd1, 5'd2, 32'h80, 32'd2, 32'd0, 5'd12), 0); release_out();
    issue(mk(R_OPC, 7'h00, 3'd3, 5'd1, 5'd2, 32'h1, 32'd2, 32'd0, 5'd13), 0);  release_out();
    // divide by zero
    issue(mk(R_OPC, 7'h01, 3'd4, 5'd1, 5'd2, 32'd9, 32'd0, 32'd0, 5'd14), 0); release_out();
    issue(mk(R_OPC, 7'h01, 3'd6, 5'd1, 5'd2, 32'd9, 32'd0, 32'd0, 5'd15), 0); release_out();

    // reset in the middle of a mul
    t = mk(R_OPC, 7'h01, 3'd0, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 5'd16);
    in_opcode = t.opc; in_funct3 = t.f3; in_funct7 = t.f7; in_rs1 = t.rs1; in_rs2 = t.rs2;
    in_rs1_val = t.v1; in_rs2_val = t.v2; in_rd = t.rd; fwd_valid = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_op", 32'(alu_op), 32'hF);
    repeat (MD_LAT) begin
      @(posedge clk); #1;
      chk("mid_rst_stay", 32'(out_valid), 32'd0);
    end

    // randomized traffic with random backpressure and back-to-back accepts
    issue(rnd_ins(), 0);
    for (int i = 0; i < 200; i++) begin
      hold($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) issue(rnd_ins(), 1);
      else begin
        release_out();
        issue(rnd_ins(), 0);
      end
    end
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Execute-stage front end that directly feeds the 32-bit ALU and captures what it produces. Sits between decode and memory stage:
- accepts one decoded RV32 ALU instruction per handshake
- applies register forwarding, selects operands and translates to the 4-bit ALU op code
- drives the ALU, waits a fixed latency, then holds the registered result for the memory stage.

Parameters:
MD_LAT, 4, ALU settle cycles for mul/div/rem (1..15); all other ops settle in 1 cycle
XLEN, 32, datapath width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode offers instruction
in_ready  out  1  stage can accept
in_opcode  in  7  RV32 opcode
in_funct3  in  3  funct3
in_funct7  in  7  funct7
in_rs1  in  5  source reg 1 index
in_rs2  in  5  source reg 2 index
in_rs1_val  in  XLEN  regfile value rs1
in_rs2_val  in  XLEN  regfile value rs2
in_imm  in  XLEN  sign-extended immediate
in_rd  in  5  destination index
fwd_valid  in  1  memory stage has writeback pending
fwd_rd  in  5  its destination
fwd_data  in  XLEN  its value
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_op  out  4  ALU op code
alu_result  in  XLEN  ALU result
out_valid  out  1  result available
out_ready  in  1  memory stage accepts
out_result  out  XLEN  registered result
out_rd  out  5  destination index
out_illegal  out  1  instruction not executable

Behaviour:
- FSM states IDLE, EXEC, DONE. Reset from any state, including mid-EXEC, forces IDLE.
- Reset values: all outputs 0, except in_ready=1 and alu_op=4'b1111.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the operands, op, rd and illegal flag. Load the counter with 1, or with MD_LAT for op 0010/0011/0100. Go to EXEC.
- Forwarding is evaluated at acceptance only:
  - rs1 uses fwd_data if fwd_valid && fwd_rd==in_rs1 && in_rs1!=0; rs2 likewise.
- Operand B:
  - opcode 0110011 (R-type): forwarded rs2.
  - opcode 0010011 (I-type): in_imm; for slli/srli, in_imm[4:0] zero-extended.
- Op decode, R-type (funct7/funct3 -> op):
  - 0000000: 000->0000 add, 001->1000 sll, 010->1010 slt, 100->0110 xor, 101->1001 srl, 110->0101 or, 111->0111 and.
  - 0100000: 000->0001 sub.
  - 0000001: 000->0010 mul, 100->0011 div, 110->0100 rem.
- Op decode, I-type: same funct3 map as R-type funct7=0000000; slli/srli additionally require funct7=0000000.
- Any other combination (sra, sltu, mulh, other opcodes): illegal=1, op=4'b1111, no wait cycles, result 0.
- EXEC:
  - in_ready=0; alu_a/alu_b/alu_op held stable from the registers.
  - Counter decrements each cycle. When it reaches 0 (1 or MD_LAT cycles after acceptance), capture alu_result into out_result and go to DONE.
- DONE:
  - out_valid=1. out_result/out_rd/out_illegal stay stable until out_ready.
  - On out_ready, if in_valid is also high the next instruction is accepted in the same cycle (DONE->EXEC) with no bubble; else go to IDLE. in_ready=out_ready in DONE.
- Throughput: one simple op per 2 cycles minimum with out_ready held high.
- rd=0 results are still produced; suppressing the write is the writeback stage's job.

Optional Feature:
ALU_ISSUE_DIV0_TRAP_EN
- Defined: div/rem with latched B==0 skips the MD_LAT wait (1 cycle). out_result is all-ones (div) or A (rem), per RISC-V spec, instead of alu_result.
- Undefined: alu_result is captured unchanged after MD_LAT cycles.

Decomposition:
- Shared package alu_pkg: ALU op-code constants (ADD..SLT, NOP=4'b1111), opcode constants OP_R/OP_I, funct7 constants, FSM state typedef. The ALU uses the same constants.
- One sub-module: alu_op_decode. Combinational opcode/funct3/funct7 -> {alu_op, is_md, use_imm, illegal}.

Test Plan:
- add x3 = 5 + 7 (R-type, out_ready=1) -> alu_op=0000; out_valid 1 cycle after accept; out_result=12, out_rd=3.
- Forwarding:
  - sub with fwd_valid=1, fwd_rd=in_rs1=4, fwd_data=100, rs2_val=30 -> out_result=70.
  - Same with in_rs1=0 -> regfile value used.
- div 100/7 with MD_LAT=4 -> in_ready low 4 cycles; out_result=14; rem -> 2.
- Backpressure: out_ready low 3 cycles in DONE -> out_result stable, in_ready=0. Then out_ready and in_valid both high in one cycle -> next instruction accepted with no IDLE cycle.
- sra (funct7=0100000, funct3=101) -> out_illegal=1, out_result=0, latency 1.
- Reset asserted mid-EXEC of mul -> next cycle IDLE, out_valid=0, in_ready=1.
- With ALU_ISSUE_DIV0_TRAP_EN: div 9/0 -> 0xFFFFFFFF after 1 cycle; rem 9/0 -> 9.
